instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the pipelined RV32I core. Holds the PC, issues single-outstanding word requests to the instruction-memory port, and registers the returned word as `Instr_out` with its `PC_out` for the decode stage, where the immediate generator and decoder consume it. It obeys decode back-pressure (`stall`) and execute-stage redirects (branch taken, JAL/JALR), and discards any wrong-path response still in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; bits [1:0] must be 0.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `im_req`  out  1: fetch request valid.
- `im_addr`  out  32: word address of the request, always equal to the internal PC.
- `im_gnt`  in  1: memory accepts the request this cycle (qualified by `im_req`).
- `im_rvalid`  in  1: read data valid; asserted no earlier than the cycle after `im_gnt`.
- `im_rdata`  in  32: instruction word.
- `stall`  in  1: decode cannot accept a new instruction this cycle.
- `redirect`  in  1: control-flow change from execute.
- `redirect_pc`  in  32: new PC; bits [1:0] are forced to 0 internally.
- `Instr_out`  out  32: registered instruction to decode.
- `PC_out`  out  32: PC of `Instr_out`.
- `instr_valid`  out  1: `Instr_out` and `PC_out` hold a valid instruction.

## Operation
- State machine with three states:
  - REQ: issue a request.
  - WAIT: a granted request is outstanding.
  - DROP: a granted request is outstanding and its response must be discarded.
- Output register is free when `!instr_valid || !stall`.
- REQ:
  - `im_req` is driven to 1 only when the output register is free.
  - `im_gnt` with `im_req` moves the machine to WAIT.
- WAIT, on `im_rvalid`:
  - `Instr_out` <= `im_rdata`, `PC_out` <= pc, `instr_valid` <= 1.
  - pc <= pc+4, next state REQ.
- Consumption: `instr_valid` clears when decode takes the instruction (`instr_valid && !stall`) and no new word is captured that cycle. While `stall` holds, `Instr_out`, `PC_out` and `instr_valid` stay stable.
- At most one request is outstanding. A grant implies the output register is empty or consumed before the response arrives, so no skid buffer is needed.
- Redirect has priority over stall and over normal flow. In every state it clears `instr_valid` next cycle and sets pc <= {`redirect_pc`[31:2], 2'b00}.
  - REQ without `im_gnt`: `im_addr` changes to the new pc next cycle; stay in REQ. This is the only case where an ungranted address may change.
  - REQ with `im_gnt` in the same cycle: the wrong-path request was accepted; go to DROP.
  - WAIT without `im_rvalid`: go to DROP.
  - WAIT with `im_rvalid`: data is discarded and not captured; go to REQ.
  - DROP without `im_rvalid`: pc is updated; stay in DROP.
  - DROP with `im_rvalid`: pc is updated; go to REQ.
- DROP on `im_rvalid`: data is discarded and `instr_valid` is unchanged; go to REQ.
- PC arithmetic is 32-bit and wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.

## Timing
- Reset values (asynchronous):
  - State REQ, pc = `RESET_PC`.
  - `instr_valid` = 0, `Instr_out` = 32'h0000_0013 (NOP), `PC_out` = 0.
  - `im_req` is combinational from state and is 1 after reset.
- Zero-wait memory (grant in cycle N, `im_rvalid` in N+1):
  - `instr_valid` rises in N+2.
  - The next request is issued in N+2.
  - Peak throughput is one instruction per 2 cycles.
- Redirect in cycle N: the new `im_addr` is presented in N+1, or after the dropped response in DROP.
- Reset asserted mid-operation aborts any outstanding request. The memory side is reset by the same `rst_n`, so no response is expected afterwards.

## Structure
- Shared package `fetch_pkg`:
  - State enum `fetch_state_t` {REQ, WAIT, DROP}.
  - Constant `NOP_INSTR` = 32'h0000_0013.
  - Constant `PC_STEP` = 32'd4.
- Single module `instr_fetch`, no sub-module. It contains:
  - The state register.
  - The pc register.
  - The output register.
  - Combinational next-state and request logic.

## Test plan
- Reset, no stall, `im_gnt` tied to `im_req`, `im_rvalid` one cycle after grant, `im_rdata` = address ^ 32'hA5A5_0000 -> `im_addr` sequence 0,4,8,12; `instr_valid` pulses every 2 cycles with matching `PC_out`/`Instr_out`.
- Hold `stall` high 5 cycles while `instr_valid`=1 -> outputs stable, `im_req`=0 throughout; next request issued in the cycle `stall` drops.
- `redirect`=1, `redirect_pc`=32'h0000_0103 in WAIT with `im_rvalid` two cycles later -> `instr_valid` cleared, response discarded, `im_addr`=32'h0000_0100 issued the cycle after the dropped `im_rvalid`.
- `redirect` coincident with `im_rvalid` in WAIT -> data not captured, `instr_valid`=0, next `im_addr`=`redirect_pc`, no DROP entered.
- `redirect` while stalled in REQ (`im_req`=0) with `stall`=1 -> `instr_valid` clears, `im_req` reasserts with the new address the next cycle despite `stall`.
- `rst_n` pulsed low during WAIT -> `instr_valid`=0, `Instr_out`=32'h0000_0013, `im_addr`=`RESET_PC` immediately (asynchronously), fetch restarts cleanly.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
   typedef enum logic [1:0] {REQ, WAIT, DROP} fetch_state_t;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with stall, redirect and wrong-path drop
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_gnt,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] Instr_out,
   output logic [31:0] PC_out,
   output logic        instr_valid
);
   fetch_state_t state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, pc_out_q;
   logic valid_q, valid_d, free, gnt, capture;
   assign free = !valid_q || !stall;
   assign gnt = im_req && im_gnt;
   assign capture = state_q == WAIT && im_rvalid && !redirect;
   assign pc_d = redirect ? (redirect_pc & 32'hFFFF_FFFC) : capture ? pc_q + PC_STEP : pc_q;
   assign valid_d = redirect ? 1'b0 : capture ? 1'b1 : valid_q && stall;
   assign im_addr = pc_q;
   assign Instr_out = instr_q;
   assign PC_out = pc_out_q;
   assign instr_valid = valid_q;
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= REQ;
      else state_q <= state_d;
   end
   // next state: a redirect with a request in flight must drain it through DROP
   always_comb begin
      state_d = state_q;
      case (state_q)
         REQ:     state_d = gnt ? (redirect ? DROP : WAIT) : REQ;
         WAIT:    state_d = im_rvalid ? REQ : redirect ? DROP : WAIT;
         DROP:    state_d = im_rvalid ? REQ : DROP;
         default: state_d = REQ;
      endcase
   end
   // request only when the output register can take the response
   always_comb begin
      im_req = state_q == REQ && free;
   end
   // pc and output register for decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pc_out_q <= 32'h0;
         valid_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         if (capture) begin
            instr_q  <= im_rdata;
            pc_out_q <= pc_q;
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch flow, stall, redirect, drop, reset and pc wrap
module tb_instr_fetch;
   localparam logic [31:0] K = 32'hA5A5_0000;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic im_req, im_gnt, im_rvalid, stall, redirect, instr_valid;
   logic [31:0] im_addr, im_rdata, redirect_pc, Instr_out, PC_out;
   logic pend;
   logic [31:0] pend_addr;
   int cnt, lat;
   int vec = 0;
   int err = 0;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
      .im_rvalid(im_rvalid), .im_rdata(im_rdata), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .Instr_out(Instr_out), .PC_out(PC_out), .instr_valid(instr_valid)
   );

   always #5 clk = ~clk;

   // memory: grants whenever asked, answers lat cycles after the one-cycle minimum
   assign im_gnt = im_req;
   assign im_rvalid = pend && cnt == 0;
   assign im_rdata = pend_addr ^ K;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= 1'b0;
         cnt <= 0;
         pend_addr <= 32'h0;
      end else begin
         if (im_rvalid) pend <= 1'b0;
         if (im_req && im_gnt) begin
            pend <= 1'b1;
            pend_addr <= im_addr;
            cnt <= lat;
         end else if (pend && cnt > 0) cnt <= cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nx();
      @(negedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
      chk({tag, "_valid"}, {31'b0, instr_valid}, {31'b0, v});
      chk({tag, "_pc_out"}, PC_out, pc);
      chk({tag, "_instr"}, Instr_out, ins);
   endtask

   initial begin
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      lat = 0;
      nx();
      outs("reset", 1'b0, 32'h0, 32'h0000_0013);
      chk("reset_req", {31'b0, im_req}, 32'd1);
      chk("reset_addr", im_addr, 32'h0);
      // cycle 0: release reset, first request at 0
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("c0_req", {31'b0, im_req}, 32'd1);
      chk("c0_addr", im_addr, 32'h0);
      nx();
      chk("c1_req", {31'b0, im_req}, 32'd0);
      chk("c1_valid", {31'b0, instr_valid}, 32'd0);
      nx();
      outs("c2", 1'b1, 32'h0, K);
      chk("c2_addr", im_addr, 32'h4);
      nx();
      chk("c3_valid", {31'b0, instr_valid}, 32'd0);
      nx();
      outs("c4", 1'b1, 32'h4, K ^ 32'h4);
      chk("c4_addr", im_addr, 32'h8);
      nx();
      nx();
      outs("c6", 1'b1, 32'h8, K ^ 32'h8);
      chk("c6_addr", im_addr, 32'hC);
      nx();
      nx();
      outs("c8", 1'b1, 32'hC, K ^ 32'hC);
      chk("c8_req", {31'b0, im_req}, 32'd1);
      chk("c8_addr", im_addr, 32'h10);
      // stall holds the output and blocks requests
      stall = 1'b1;
      #1;
      chk("stall_req_now", {31'b0, im_req}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         nx();
         outs("stall", 1'b1, 32'hC, K ^ 32'hC);
         chk("stall_req", {31'b0, im_req}, 32'd0);
      end
      stall = 1'b0;
      #1;
      chk("unstall_req", {31'b0, im_req}, 32'd1);
      chk("unstall_addr", im_addr, 32'h10);
      nx();
      chk("c14_valid", {31'b0, instr_valid}, 32'd0);
      nx();
      outs("c15", 1'b1, 32'h10, K ^ 32'h10);
      lat = 2;
      // redirect while waiting; the late response must be dropped
      nx();
      chk("c16_valid", {31'b0, instr_valid}, 32'd0);
      chk("c16_rvalid", {31'b0, im_rvalid}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      nx();
      redirect = 1'b0;
      chk("drop_req", {31'b0, im_req}, 32'd0);
      chk("drop_valid", {31'b0, instr_valid}, 32'd0);
      nx();
      chk("drop_rvalid", {31'b0, im_rvalid}, 32'd1);
      chk("drop_req2", {31'b0, im_req}, 32'd0);
      nx();
      lat = 0;
      chk("after_drop_req", {31'b0, im_req}, 32'd1);
      chk("after_drop_addr", im_addr, 32'h100);
      outs("after_drop", 1'b0, 32'h10, K ^ 32'h10);
      // redirect coincident with a response in WAIT
      nx();
      chk("coinc_rvalid", {31'b0, im_rvalid}, 32'd1);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0200;
      nx();
      redirect = 1'b0;
      outs("coinc", 1'b0, 32'h10, K ^ 32'h10);
      chk("coinc_req", {31'b0, im_req}, 32'd1);
      chk("coinc_addr", im_addr, 32'h200);
      nx();
      nx();
      outs("coinc_fetch", 1'b1, 32'h200, K ^ 32'h200);
      // redirect while stalled in REQ
      stall = 1'b1;
      #1;
      chk("stallreq_req", {31'b0, im_req}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0304;
      nx();
      redirect = 1'b0;
      chk("stallredir_valid", {31'b0, instr_valid}, 32'd0);
      chk("stallredir_req", {31'b0, im_req}, 32'd1);
      chk("stallredir_addr", im_addr, 32'h304);
      stall = 1'b0;
      nx();
      nx();
      outs("stallredir_fetch", 1'b1, 32'h304, K ^ 32'h304);
      chk("c26_addr", im_addr, 32'h308);
      // asynchronous reset in WAIT
      nx();
      rst_n = 1'b0;
      #1;
      outs("areset", 1'b0, 32'h0, 32'h0000_0013);
      chk("areset_addr", im_addr, 32'h0);
      chk("areset_req", {31'b0, im_req}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("restart_addr", im_addr, 32'h0);
      nx();
      nx();
      outs("restart", 1'b1, 32'h0, K);
      chk("restart_addr2", im_addr, 32'h4);
      // pc wrap past the top of the address space
      nx();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      nx();
      redirect = 1'b0;
      chk("wrap_addr", im_addr, 32'hFFFF_FFFC);
      nx();
      nx();
      outs("wrap", 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
      chk("wrap_next_addr", im_addr, 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
